// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N:1 packet-stream mux, locks one channel per in_last-delimited packet; MUX_RR_EN selects round-robin arbitration instead of sel
module mux_nto1_stream #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [SEL_W-1:0]      cur_ch
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t           state;
    logic             lock_req;
    logic [SEL_W-1:0] lock_ch;
    logic             xfer;
`ifdef MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;
    logic             unused_sel;
    assign unused_sel = ^sel;
    // first valid channel at or after rr_ptr, wrapping; lowest offset wins
    always_comb begin
        lock_req = 1'b0;
        lock_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (in_valid[SEL_W'((32'(rr_ptr) + i) % N_CH)]) begin
                lock_req = 1'b1;
                lock_ch  = SEL_W'((32'(rr_ptr) + i) % N_CH);
            end
        end
    end
    // search start moves to the channel after the latest grant; channel 0 after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (state == IDLE && lock_req)
            rr_ptr <= (32'(lock_ch) == N_CH - 1) ? '0 : lock_ch + 1'b1;
    end
`else
    assign lock_req = (32'(sel) < N_CH) && in_valid[sel];
    assign lock_ch  = sel;
`endif
    // only the locked channel may be accepted, and only when the output slot frees up
    always_comb begin
        in_ready = '0;
        if (state == LOCK)
            in_ready[cur_ch] = !out_valid || out_ready;
    end
    assign xfer = (state == LOCK) && in_valid[cur_ch] && in_ready[cur_ch];
    // packet-lock FSM plus output register with same-cycle drain and load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cur_ch    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == IDLE) begin
                if (lock_req) begin
                    state  <= LOCK;
                    busy   <= 1'b1;
                    cur_ch <= lock_ch;
                end
            end else if (xfer && in_last[cur_ch]) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[32'(cur_ch) * WIDTH +: WIDTH];
                out_last  <= in_last[cur_ch];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: directed checks of the N:1 packet-stream mux (sel build, or round-robin when MUX_RR_EN is defined)
module tb_mux_nto1_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  sel = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0, in_last = '0, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_last, out_ready = 1'b1, busy;
    logic [1:0]  cur_ch;
    logic [2:0]  sel5 = '0;
    logic [39:0] in_data5 = '0;
    logic [4:0]  in_valid5 = '0, in_last5 = '0, in_ready5;
    logic [7:0]  out_data5;
    logic        out_valid5, out_last5, out_ready5 = 1'b1, busy5;
    logic [2:0]  cur_ch5;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    mux_nto1_stream #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .cur_ch(cur_ch)
    );

    mux_nto1_stream #(.N_CH(5), .WIDTH(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .sel(sel5), .in_data(in_data5), .in_valid(in_valid5),
        .in_last(in_last5), .in_ready(in_ready5), .out_data(out_data5), .out_valid(out_valid5),
        .out_last(out_last5), .out_ready(out_ready5), .busy(busy5), .cur_ch(cur_ch5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outs", {out_valid, out_last, busy, cur_ch, out_data}, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_after_rst", {busy, out_valid, in_ready}, 0);
`ifdef MUX_RR_EN
        begin
            int g[6] = '{0, 1, 3, 0, 1, 3};
            in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
            in_valid = 4'b1011;
            in_last  = 4'b1111;
            for (int i = 0; i < 6; i++) begin
                tick();
                chk("rr_grant", cur_ch, g[i]);
                chk("rr_busy", busy, 1);
                tick();
                chk("rr_data", {out_valid, out_last, out_data}, {2'b11, 8'h10 + 8'(g[i])});
            end
            tick();
            chk("rr_grant_again", cur_ch, 0);
            tick();
            in_last = 4'b0000;
            tick();
            chk("rr_lock_ch1", cur_ch, 1);
            tick();
            chk("rr_midpkt", {busy, out_valid, out_data}, {2'b11, 8'h11});
            rst_n = 1'b0;
            #1;
            chk("rr_rst_now", {out_valid, busy, cur_ch, in_ready}, 0);
            tick();
            rst_n = 1'b1;
            in_last = 4'b1111;
            tick();
            chk("rr_after_rst", {busy, cur_ch}, {1'b1, 2'd0});
        end
`else
        sel = 2'd2;
        in_data[16 +: 8] = 8'hA1;
        in_valid = 4'b0100;
        tick();
        chk("s2_lock", {busy, cur_ch, out_valid}, {1'b1, 2'd2, 1'b0});
        chk("s2_lock_rdy", in_ready, 4'b0100);
        tick();
        chk("s2_b1", {out_valid, out_last, out_data}, {2'b10, 8'hA1});
        in_data[16 +: 8] = 8'hA2;
        tick();
        chk("s2_b2", {out_valid, out_last, out_data}, {2'b10, 8'hA2});
        in_data[16 +: 8] = 8'hA3;
        in_last = 4'b0100;
        tick();
        chk("s2_b3", {out_valid, out_last, out_data}, {2'b11, 8'hA3});
        chk("s2_end", {busy, in_ready}, 0);
        in_valid = '0;
        in_last  = '0;
        tick();
        chk("s2_drain", out_valid, 0);

        in_data[16 +: 8] = 8'hB1;
        in_valid = 4'b0100;
        tick();
        sel = 2'd1;
        in_data[8 +: 8] = 8'hC1;
        in_valid = 4'b0110;
        in_last  = 4'b0010;
        #1;
        chk("s3_hold_rdy", in_ready, 4'b0100);
        tick();
        chk("s3_b1", {out_valid, out_data, in_ready}, {1'b1, 8'hB1, 4'b0100});
        in_data[16 +: 8] = 8'hB2;
        in_last = 4'b0110;
        tick();
        chk("s3_b2", {out_valid, out_last, out_data}, {2'b11, 8'hB2});
        chk("s3_end", {busy, in_ready}, 0);
        in_valid = 4'b0010;
        tick();
        chk("s3_lock1", {busy, cur_ch, in_ready}, {1'b1, 2'd1, 4'b0010});
        tick();
        chk("s3_c1", {out_valid, out_last, out_data, busy}, {2'b11, 8'hC1, 1'b0});
        in_valid = '0;
        in_last  = '0;
        tick();

        sel = 2'd0;
        out_ready = 1'b0;
        in_data[0 +: 8] = 8'hD1;
        in_valid = 4'b0001;
        tick();
        chk("s4_lock_rdy", in_ready, 4'b0001);
        tick();
        chk("s4_d1", {out_valid, out_data, in_ready}, {1'b1, 8'hD1, 4'b0000});
        in_data[0 +: 8] = 8'hD2;
        tick();
        chk("s4_hold1", {out_valid, out_data, in_ready}, {1'b1, 8'hD1, 4'b0000});
        tick();
        chk("s4_hold2", {out_valid, out_data}, {1'b1, 8'hD1});
        out_ready = 1'b1;
        #1;
        chk("s4_rdy_back", in_ready, 4'b0001);
        tick();
        chk("s4_d2", {out_valid, out_last, out_data}, {2'b10, 8'hD2});
        in_data[0 +: 8] = 8'hD3;
        in_last = 4'b0001;
        tick();
        chk("s4_d3", {out_valid, out_last, out_data, busy}, {2'b11, 8'hD3, 1'b0});
        in_valid = '0;
        in_last  = '0;
        tick();
        chk("s4_drain", out_valid, 0);

        sel = 2'd3;
        in_data[24 +: 8] = 8'hE1;
        in_valid = 4'b1000;
        tick();
        tick();
        chk("rst_mid_pre", {busy, out_valid, out_data}, {2'b11, 8'hE1});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_now", {out_valid, out_last, busy, cur_ch, out_data, in_ready}, 0);
        in_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        sel5 = 3'd7;
        in_valid5 = '1;
        in_last5  = '1;
        in_data5[32 +: 8] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s5_oor_idle", {busy5, in_ready5, out_valid5}, 0);
        end
        sel5 = 3'd4;
        tick();
        chk("s5_lock4", {busy5, cur_ch5, in_ready5}, {1'b1, 3'd4, 5'b10000});
        tick();
        chk("s5_beat", {out_valid5, out_last5, out_data5, busy5}, {2'b11, 8'h55, 1'b0});
        in_valid5 = '0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
